coherence_ctrl: RTL

Memory-side coherence controller and bus arbiter for a dual-core system. It sits between the two data caches and the single-ported RAM. It grants one cache at a time using round-robin arbitration and passes that cache's word reads and writes through to RAM. Before any read phase it snoops the other cache; if the other cache holds the line dirty, the controller forces it to write the line back to RAM first, so the requester always reads coherent data.

---
 rtl/coherence_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/coherence_ctrl.sv
// coherence_ctrl: memory-side coherence controller and round-robin bus arbiter
// for two data caches sharing one single-ported RAM.
// Build option: define CC_SNOOP_EN to enable snooping and the forced write-back of
// dirty lines. Without it the block is a plain IDLE/SERVE round-robin arbiter.
module coherence_ctrl #(
  parameter int WORDS_PER_BLOCK = 2,
  parameter int AW              = 32
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [1:0]           cdREN,
  input  logic [1:0]           cdWEN,
  input  logic [1:0][AW-1:0]   cdaddr,
  input  logic [1:0][AW-1:0]   cdstore,
  output logic [1:0][AW-1:0]   cdload,
  output logic [1:0]           dwait,
  output logic [1:0]           ccwait,
  output logic [1:0]           ccwrite,
  output logic [1:0][AW-1:0]   ccsnoopaddr,
  input  logic [1:0]           ccdirty,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [AW-1:0]        ramaddr,
  output logic [AW-1:0]        ramstore,
  input  logic [AW-1:0]        ramload,
  input  logic                 ramwait
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    SNOOP = 3'd2,
    INV   = 3'd3,
    SWB   = 3'd4
  } state_e;

  state_e     state_q, state_d;
  // last_q doubles as the current grant: it is loaded with the winner on every grant.
  logic       last_q, last_d;
  logic       r;
  logic [1:0] req;

  assign r   = last_q;
  assign req = cdREN | cdWEN;

`ifdef CC_SNOOP_EN
  localparam int CW = $clog2(WORDS_PER_BLOCK) + 1;
  logic          s;
  logic          snooped_q, snooped_d;
  logic [CW-1:0] count_q, count_d;

  assign s = ~last_q;
`else
  // Snoop inputs have no effect when snooping is compiled out.
  logic unused_ccdirty;
  assign unused_ccdirty = ^ccdirty;
`endif

  // Both read-data lanes always mirror the RAM read bus.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_load
      assign cdload[gi] = ramload;
    end
  endgenerate

  // State, round-robin pointer, snoop flag and write-back word count.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      last_q    <= 1'b0;
`ifdef CC_SNOOP_EN
      snooped_q <= 1'b0;
      count_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
`ifdef CC_SNOOP_EN
      snooped_q <= snooped_d;
      count_q   <= count_d;
`endif
    end
  end

  // Next-state logic and output decode of the current state.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    dwait       = 2'b11;
    ccwait      = 2'b00;
    ccwrite     = 2'b00;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
`ifdef CC_SNOOP_EN
    snooped_d   = snooped_q;
    count_d     = count_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          // Contention goes to the core that was not granted last time.
          last_d  = (&req) ? ~last_q : req[1];
`ifdef CC_SNOOP_EN
          snooped_d = 1'b0;
`endif
          state_d = SERVE;
        end
      end
      SERVE: begin
`ifdef CC_SNOOP_EN
        // A read phase that has not been snooped yet detours through SNOOP
        // without touching the RAM, so stale data is never returned.
        if (cdREN[r] && !snooped_q) begin
          state_d = SNOOP;
        end else
`endif
        begin
          ramREN   = cdREN[r];
          ramWEN   = cdWEN[r];
          ramaddr  = cdaddr[r];
          ramstore = cdstore[r];
          dwait[r] = ramwait;
          if (!req[r]) begin
            state_d = IDLE;
          end
        end
      end
`ifdef CC_SNOOP_EN
      SNOOP: begin
        ccwait[s]      = 1'b1;
        ccsnoopaddr[s] = cdaddr[r];
        snooped_d      = 1'b1;
        state_d        = ccdirty[s] ? INV : SERVE;
      end
      INV: begin
        // One-cycle pulse: a longer ccwrite would restart the cache write-back.
        ccwait[s]  = 1'b1;
        ccwrite[s] = 1'b1;
        count_d    = '0;
        state_d    = SWB;
      end
      SWB: begin
        ccwait[s] = 1'b1;
        ramREN    = cdREN[s];
        ramWEN    = cdWEN[s];
        ramaddr   = cdaddr[s];
        ramstore  = cdstore[s];
        dwait[s]  = ramwait;
        if (cdWEN[s] && !ramwait) begin
          if (count_q == CW'(WORDS_PER_BLOCK - 1)) begin
            state_d = SERVE;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
